// File: rtl/ppu_pkg.sv
// Shared PPU constants and helpers: dot-window boundaries for the background
// pixel pipe and the attribute-quadrant selector.
package ppu_pkg;

  localparam int unsigned DOT_LAST_DEFAULT = 340;

  localparam logic [8:0] DOT_SHIFT_A_FIRST = 9'd2;
  localparam logic [8:0] DOT_SHIFT_A_LAST  = 9'd257;
  localparam logic [8:0] DOT_SHIFT_B_FIRST = 9'd322;
  localparam logic [8:0] DOT_SHIFT_B_LAST  = 9'd337;
  localparam logic [8:0] DOT_RELOAD_FIRST  = 9'd9;
  localparam logic [8:0] DOT_PIX_FIRST     = 9'd1;
  localparam logic [8:0] DOT_PIX_LAST      = 9'd256;
  localparam logic [8:0] DOT_CLIP_LAST     = 9'd8;

  typedef struct packed {
    logic at_hi;
    logic at_lo;
    logic pat_hi;
    logic pat_lo;
  } bg_pix_t;

  // Each attribute byte covers four 2x2-tile quadrants, two bits apiece.
  function automatic logic [1:0] attr_select(input logic [7:0] at_byte,
                                             input logic [1:0] quad);
    logic [1:0] r;
    case (quad)
      2'd0:    r = at_byte[1:0];
      2'd1:    r = at_byte[3:2];
      2'd2:    r = at_byte[5:4];
      default: r = at_byte[7:6];
    endcase
    return r;
  endfunction

  function automatic logic in_range(input logic [8:0] v,
                                    input logic [8:0] lo,
                                    input logic [8:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/ppu_bg_shifter.sv
// 16-bit background shifter: shifts left one bit per dot, and on a tile
// boundary shifts while dropping the next tile's byte into the low half.
module ppu_bg_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        shift_i,
  input  logic        reload_i,
  input  logic [7:0]  load_i,
  output logic [15:0] q_o
);

  logic [15:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (reload_i) begin
      sh_d = {sh_q[14:7], load_i};
    end else if (shift_i) begin
      sh_d = {sh_q[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign q_o = sh_q;

endmodule

// File: rtl/ppu_bg_pixel_pipe.sv
// Background pixel pipe: latches fetched attribute/pattern bytes, reloads them
// into shifters at tile boundaries and emits one fine-X-selected index per dot.
module ppu_bg_pixel_pipe
  import ppu_pkg::*;
#(
  parameter int CLK_PER_DOT = 4,
  parameter int LAST_DOT    = DOT_LAST_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_start,
  input  logic       row_visible,
  input  logic       render_en,
  input  logic [7:0] vram_data,
  input  logic       at_we,
  input  logic       ptl_we,
  input  logic       pth_we,
  input  logic [1:0] at_quad,
  input  logic [2:0] fine_x,
  input  logic       bg_en,
  input  logic       bg_left_en,
  output logic [3:0] pix,
  output logic       pix_valid,
  output logic [8:0] dot_cnt
);

  localparam int PH_W = (CLK_PER_DOT > 1) ? $clog2(CLK_PER_DOT) : 1;

  logic [PH_W-1:0] phase_q, phase_d;
  logic [8:0]      dot_q, dot_d;
  logic [1:0]      at_lat_q, at_lat_d;
  logic [7:0]      lo_lat_q, lo_lat_d;
  logic [7:0]      hi_lat_q, hi_lat_d;
  bg_pix_t         pix_q, pix_d;
  logic            pix_valid_q, pix_valid_d;

  logic            tick;
  logic            shift_win;
  logic            reload;
  logic            sample;
  logic            clip;
  logic [3:0]      bit_idx;
  bg_pix_t         raw_pix;
  logic [15:0]     pat_lo_sh, pat_hi_sh, at_lo_sh, at_hi_sh;

  assign tick = (phase_q == PH_W'(CLK_PER_DOT - 1));

  assign shift_win = tick && render_en &&
                     (in_range(dot_q, DOT_SHIFT_A_FIRST, DOT_SHIFT_A_LAST) ||
                      in_range(dot_q, DOT_SHIFT_B_FIRST, DOT_SHIFT_B_LAST));

  // Tile boundaries fall on dots ending in 3'b001, from dot 9 onward.
  assign reload = shift_win && (dot_q[2:0] == 3'd1) && (dot_q >= DOT_RELOAD_FIRST);

  assign sample = tick && row_visible && in_range(dot_q, DOT_PIX_FIRST, DOT_PIX_LAST);
  assign clip   = !bg_left_en && (dot_q <= DOT_CLIP_LAST);

  always_comb begin
    phase_d = tick ? '0 : phase_q + PH_W'(1);
    dot_d   = dot_q;
    if (tick && (dot_q < 9'(LAST_DOT))) begin
      dot_d = dot_q + 9'd1;
    end
    if (line_start) begin
      phase_d = '0;
      dot_d   = '0;
    end
  end

  // Latches update through registers, so a reload on the same clk sees old values.
  always_comb begin
    at_lat_d = at_lat_q;
    lo_lat_d = lo_lat_q;
    hi_lat_d = hi_lat_q;
    if (at_we) begin
      at_lat_d = attr_select(vram_data, at_quad);
    end
    if (ptl_we) begin
      lo_lat_d = vram_data;
    end
    if (pth_we) begin
      hi_lat_d = vram_data;
    end
  end

  always_comb begin
    bit_idx        = 4'd15 - {1'b0, fine_x};
    raw_pix.at_hi  = at_hi_sh[bit_idx];
    raw_pix.at_lo  = at_lo_sh[bit_idx];
    raw_pix.pat_hi = pat_hi_sh[bit_idx];
    raw_pix.pat_lo = pat_lo_sh[bit_idx];
    pix_d          = pix_q;
    if (sample) begin
      pix_d = (bg_en && !clip) ? raw_pix : '0;
    end
    pix_valid_d = sample;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= '0;
      dot_q       <= '0;
      at_lat_q    <= '0;
      lo_lat_q    <= '0;
      hi_lat_q    <= '0;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      dot_q       <= dot_d;
      at_lat_q    <= at_lat_d;
      lo_lat_q    <= lo_lat_d;
      hi_lat_q    <= hi_lat_d;
      pix_q       <= pix_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  ppu_bg_shifter u_pat_lo (
    .clk      (clk),
    .rst      (rst),
    .shift_i  (shift_win),
    .reload_i (reload),
    .load_i   (lo_lat_q),
    .q_o      (pat_lo_sh)
  );

  ppu_bg_shifter u_pat_hi (
    .clk      (clk),
    .rst      (rst),
    .shift_i  (shift_win),
    .reload_i (reload),
    .load_i   (hi_lat_q),
    .q_o      (pat_hi_sh)
  );

  ppu_bg_shifter u_at_lo (
    .clk      (clk),
    .rst      (rst),
    .shift_i  (shift_win),
    .reload_i (reload),
    .load_i   ({8{at_lat_q[0]}}),
    .q_o      (at_lo_sh)
  );

  ppu_bg_shifter u_at_hi (
    .clk      (clk),
    .rst      (rst),
    .shift_i  (shift_win),
    .reload_i (reload),
    .load_i   ({8{at_lat_q[1]}}),
    .q_o      (at_hi_sh)
  );

  assign pix       = pix_q;
  assign pix_valid = pix_valid_q;
  assign dot_cnt   = dot_q;

endmodule

// File: tb/tb_ppu_bg_pixel_pipe.sv
// Randomized bench for ppu_bg_pixel_pipe against a dot-level reference model.
module tb_ppu_bg_pixel_pipe;

  localparam int CPD  = 4;
  localparam int LAST = 340;

  logic       clk = 1'b0;
  logic       rst;
  logic       line_start;
  logic       row_visible;
  logic       render_en;
  logic [7:0] vram_data;
  logic       at_we;
  logic       ptl_we;
  logic       pth_we;
  logic [1:0] at_quad;
  logic [2:0] fine_x;
  logic       bg_en;
  logic       bg_left_en;
  logic [3:0] pix;
  logic       pix_valid;
  logic [8:0] dot_cnt;

  always #5 clk = ~clk;

  ppu_bg_pixel_pipe #(.CLK_PER_DOT(CPD), .LAST_DOT(LAST)) dut (
    .clk         (clk),
    .rst         (rst),
    .line_start  (line_start),
    .row_visible (row_visible),
    .render_en   (render_en),
    .vram_data   (vram_data),
    .at_we       (at_we),
    .ptl_we      (ptl_we),
    .pth_we      (pth_we),
    .at_quad     (at_quad),
    .fine_x      (fine_x),
    .bg_en       (bg_en),
    .bg_left_en  (bg_left_en),
    .pix         (pix),
    .pix_valid   (pix_valid),
    .dot_cnt     (dot_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  int vld_cnt;

  // Reference state: dot timing as integers, shifters as plain 16-bit numbers.
  int          m_phase, m_dot;
  logic [15:0] m_pl, m_ph, m_al, m_ah;
  logic [7:0]  m_lo, m_hi;
  logic [1:0]  m_at;
  logic [3:0]  m_pix;
  logic        m_vld;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t, model dot %0d)", tag, got, exp, $time, m_dot);
    end
  endtask

  task automatic model_clear();
    m_phase = 0; m_dot = 0;
    m_pl = 0; m_ph = 0; m_al = 0; m_ah = 0;
    m_lo = 0; m_hi = 0; m_at = 0;
    m_pix = 0; m_vld = 0;
  endtask

  task automatic model_clock();
    bit  tick, win, rel;
    int  d, b;
    logic [7:0] alo, ahi;
    if (rst) begin
      model_clear();
      return;
    end
    d    = m_dot;
    tick = (m_phase == CPD - 1);
    win  = render_en && tick && ((d >= 2 && d <= 257) || (d >= 322 && d <= 337));
    rel  = win && (d % 8 == 1) && (d >= 9);
    b    = 15 - int'(fine_x);
    if (tick && row_visible && d >= 1 && d <= 256) begin
      if (bg_en && (bg_left_en || d > 8))
        m_pix = {m_ah[b], m_al[b], m_ph[b], m_pl[b]};
      else
        m_pix = 4'h0;
      m_vld = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
    alo = m_at[0] ? 8'hFF : 8'h00;
    ahi = m_at[1] ? 8'hFF : 8'h00;
    if (rel) begin
      m_pl = ((m_pl << 1) & 16'hFF00) | {8'h00, m_lo};
      m_ph = ((m_ph << 1) & 16'hFF00) | {8'h00, m_hi};
      m_al = ((m_al << 1) & 16'hFF00) | {8'h00, alo};
      m_ah = ((m_ah << 1) & 16'hFF00) | {8'h00, ahi};
    end else if (win) begin
      m_pl = m_pl << 1;
      m_ph = m_ph << 1;
      m_al = m_al << 1;
      m_ah = m_ah << 1;
    end
    if (at_we)  m_at = 2'((vram_data >> (2 * int'(at_quad))) & 8'h03);
    if (ptl_we) m_lo = vram_data;
    if (pth_we) m_hi = vram_data;
    if (line_start) begin
      m_phase = 0;
      m_dot   = 0;
    end else begin
      m_phase = (m_phase + 1) % CPD;
      if (tick && m_dot < LAST) m_dot = m_dot + 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check("pix", 16'(pix), 16'(m_pix));
    check("pix_valid", 16'(pix_valid), 16'(m_vld));
    check("dot_cnt", 16'(dot_cnt), 16'(m_dot));
    if (pix_valid) vld_cnt++;
  endtask

  task automatic clear_strobes();
    rst = 0; line_start = 0; at_we = 0; ptl_we = 0; pth_we = 0;
  endtask

  // fx < 0 randomizes fine_x every clk; mid_ls / rst_at < 0 disable those events.
  task automatic run_line(input bit rv, input bit ren, input bit bge, input bit bgl,
                          input int fx, input int mid_ls, input int rst_at,
                          input int exp_pulses);
    bit ls_done = 0, rst_done = 0;
    row_visible = rv; render_en = ren; bg_en = bge; bg_left_en = bgl;
    if (fx >= 0) fine_x = 3'(fx);
    clear_strobes();
    line_start = 1;
    vld_cnt = 0;
    step();
    for (int k = 0; k < (LAST + 1) * CPD - 1; k++) begin
      clear_strobes();
      vram_data = 8'($urandom);
      at_quad   = 2'($urandom_range(0, 3));
      at_we     = ($urandom_range(0, 11) == 0);
      ptl_we    = ($urandom_range(0, 11) == 0);
      pth_we    = ($urandom_range(0, 11) == 0);
      if (fx < 0) fine_x = 3'($urandom_range(0, 7));
      if (m_dot == 17 && m_phase == CPD - 1) ptl_we = 1;
      if (!ls_done && mid_ls >= 0 && m_dot == mid_ls && m_phase == 1) begin
        line_start = 1; ls_done = 1;
      end
      if (!rst_done && rst_at >= 0 && m_dot == rst_at && m_phase == 2) begin
        rst = 1; rst_done = 1;
      end
      step();
      if (rst_done && rst === 1'b1) begin
        check("rst_pix", 16'(pix), 16'h0);
        check("rst_dot", 16'(dot_cnt), 16'h0);
        check("rst_sh", dut.u_pat_lo.q_o | dut.u_pat_hi.q_o | dut.u_at_lo.q_o | dut.u_at_hi.q_o, 16'h0);
      end
    end
    clear_strobes();
    if (exp_pulses >= 0) check("pulse_count", 16'(vld_cnt), 16'(exp_pulses));
  endtask

  initial begin
    model_clear();
    clear_strobes();
    row_visible = 0; render_en = 0; bg_en = 0; bg_left_en = 0;
    vram_data = 0; at_quad = 0; fine_x = 0;
    rst = 1;
    repeat (3) step();
    rst = 0;
    check("reset_pix", 16'(pix), 16'h0);
    check("reset_valid", 16'(pix_valid), 16'h0);

    run_line(0, 1, 1, 1, 0,  -1, -1, 0);    // pre-render line fetches tiles 0/1
    run_line(1, 1, 1, 1, 0,  -1, -1, 256);
    run_line(1, 1, 1, 1, 7,  -1, -1, 256);
    run_line(1, 1, 1, 0, -1, -1, -1, 256);  // left clip
    run_line(1, 1, 0, 1, -1, -1, -1, 256);  // background disabled
    run_line(1, 0, 1, 1, -1, -1, -1, 256);  // shifters frozen
    run_line(0, 1, 1, 1, -1, -1, -1, 0);
    run_line(1, 1, 1, 1, -1, 150, -1, -1);  // mid-line restart
    run_line(1, 1, 1, 1, -1, -1, 100, -1);  // reset at dot 100
    for (int i = 0; i < 4; i++) begin
      run_line(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
               1'($urandom), -1, -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
